// File: rtl/source_queue_if.sv
// Host/consumer-facing signal bundle for source_queue: push side, occupancy status and head-of-queue delivery.
// The master modport is the environment (host + consumer); the slave modport is the queue itself.
interface source_queue_if #(
   parameter int DEPTH = 8
);
   logic                     wr_en;
   logic [10:0]              wr_data;
   logic                     full;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;
   logic                     rready;
   logic [10:0]              out;
   logic                     read;

   modport master (
      output wr_en, wr_data, read,
      input  full, count, overflow, rready, out
   );

   modport slave (
      input  wr_en, wr_data, read,
      output full, count, overflow, rready, out
   );
endinterface

// File: rtl/source_queue.sv
// Circular-buffer source queue feeding an 11-bit consumer; optional SOURCE_QUEUE_CLAMP_EN saturates pushes to +/-999.
// Latency: push into an empty queue shows on rready/out one cycle later; pop takes effect on the read edge.
// Backpressure: host sees full; a push while full is dropped unless a pop happens the same cycle, which sets sticky overflow.
module source_queue #(
   parameter int DEPTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   source_queue_if.slave  q
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [10:0]   mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] cnt;
   logic          ovf;
   logic          nonempty;
   logic          is_full;
   logic          pop;
   logic          push;
   logic [10:0]   wdat;

   assign nonempty = (cnt != '0);
   assign is_full  = (cnt == FULL_CNT);
   // A read against an empty queue is simply ignored; a full queue still accepts when it pops.
   assign pop      = q.read && nonempty;
   assign push     = q.wr_en && (!is_full || pop);

`ifdef SOURCE_QUEUE_CLAMP_EN
   localparam logic signed [10:0] CLAMP_HI = 11'sd999;
   localparam logic signed [10:0] CLAMP_LO = -11'sd999;

   always_comb begin
      wdat = q.wr_data;
      if ($signed(q.wr_data) > CLAMP_HI)
         wdat = CLAMP_HI;
      else if ($signed(q.wr_data) < CLAMP_LO)
         wdat = CLAMP_LO;
   end
`else
   assign wdat = q.wr_data;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
      end else begin
         if (pop)
            head <= head + AW'(1);
         if (push)
            tail <= tail + AW'(1);
         if (push && !pop)
            cnt <= cnt + CW'(1);
         else if (pop && !push)
            cnt <= cnt - CW'(1);
         if (q.wr_en && !push)
            ovf <= 1'b1;
      end
   end

   // Storage needs no reset: cnt gates visibility, so stale entries never reach out.
   always_ff @(posedge clk) begin
      if (push)
         mem[tail] <= wdat;
   end

   assign q.rready   = nonempty;
   assign q.out      = nonempty ? mem[head] : '0;
   assign q.full     = is_full;
   assign q.count    = cnt;
   assign q.overflow = ovf;
endmodule

// File: tb/tb_source_queue.sv
// Self-checking bench for source_queue: directed table, hand-written corner sequences, then randomized traffic against a queue model.
module tb_source_queue;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   source_queue_if #(.DEPTH(DEPTH)) qif ();
   source_queue #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .q   (qif)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int mq[$];
   bit movf = 1'b0;

   typedef struct {
      bit we;
      int wd;
      bit rd;
      int cnt;
      bit rr;
      int dout;
      bit ovf;
   } vec_t;
   vec_t tbl[12];

   function automatic int sat(int v);
`ifdef SOURCE_QUEUE_CLAMP_EN
      if (v > 999) return 999;
      if (v < -999) return -999;
`endif
      return v;
   endfunction

   function automatic int dout();
      return int'($signed(qif.out));
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_model(string nm);
      chk({nm, "_count"}, int'(qif.count), mq.size());
      chk({nm, "_full"}, int'(qif.full), int'(mq.size() == DEPTH));
      chk({nm, "_rready"}, int'(qif.rready), int'(mq.size() != 0));
      chk({nm, "_out"}, dout(), (mq.size() != 0) ? mq[0] : 0);
      chk({nm, "_overflow"}, int'(qif.overflow), int'(movf));
   endtask

   // One clock of stimulus; the model applies the queue rules to the same inputs.
   task automatic step(bit we, int wd, bit rd);
      bit pop;
      bit acc;
      qif.wr_en   = we;
      qif.wr_data = 11'(wd);
      qif.read    = rd;
      @(posedge clk);
      #1;
      pop = rd && (mq.size() != 0);
      acc = we && ((mq.size() < DEPTH) || pop);
      if (we && !acc) movf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(sat(wd));
      qif.wr_en = 1'b0;
      qif.read  = 1'b0;
   endtask

   task automatic do_reset();
      qif.wr_en   = 1'b0;
      qif.wr_data = '0;
      qif.read    = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mq.delete();
      movf = 1'b0;
      rst  = 1'b1;
   endtask

   initial begin
      int e1;
      int e2;
      logic [10:0] r;
      int pw;
      int pr;

      qif.wr_en   = 1'b0;
      qif.wr_data = '0;
      qif.read    = 1'b0;
      #1 rst = 1'b0;
      #10;
      chk("rst_count", int'(qif.count), 0);
      chk("rst_full", int'(qif.full), 0);
      chk("rst_overflow", int'(qif.overflow), 0);
      chk("rst_rready", int'(qif.rready), 0);
      chk("rst_out", dout(), 0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Ordered delivery with a read every other cycle, then empty-read and push/read-while-empty.
      tbl[0]  = '{1'b1,  5, 1'b0, 1, 1'b1,  5, 1'b0};
      tbl[1]  = '{1'b1,  7, 1'b0, 2, 1'b1,  5, 1'b0};
      tbl[2]  = '{1'b1, -3, 1'b0, 3, 1'b1,  5, 1'b0};
      tbl[3]  = '{1'b0,  0, 1'b1, 2, 1'b1,  7, 1'b0};
      tbl[4]  = '{1'b0,  0, 1'b0, 2, 1'b1,  7, 1'b0};
      tbl[5]  = '{1'b0,  0, 1'b1, 1, 1'b1, -3, 1'b0};
      tbl[6]  = '{1'b0,  0, 1'b0, 1, 1'b1, -3, 1'b0};
      tbl[7]  = '{1'b0,  0, 1'b1, 0, 1'b0,  0, 1'b0};
      tbl[8]  = '{1'b0,  0, 1'b1, 0, 1'b0,  0, 1'b0};
      tbl[9]  = '{1'b1, 42, 1'b1, 1, 1'b1, 42, 1'b0};
      tbl[10] = '{1'b1, 10, 1'b1, 1, 1'b1, 10, 1'b0};
      tbl[11] = '{1'b0,  0, 1'b1, 0, 1'b0,  0, 1'b0};
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].we, tbl[i].wd, tbl[i].rd);
         chk($sformatf("tbl%0d_count", i), int'(qif.count), tbl[i].cnt);
         chk($sformatf("tbl%0d_rready", i), int'(qif.rready), int'(tbl[i].rr));
         chk($sformatf("tbl%0d_out", i), dout(), tbl[i].dout);
         chk($sformatf("tbl%0d_overflow", i), int'(qif.overflow), int'(tbl[i].ovf));
      end

      // Overflow: nine pushes into eight slots, drain yields 1..8.
      do_reset();
      for (int v = 1; v <= 9; v++) begin
         step(1'b1, v, 1'b0);
         if (v == 8) begin
            chk("ovf_full8", int'(qif.full), 1);
            chk("ovf_flag8", int'(qif.overflow), 0);
         end
      end
      chk("ovf_count9", int'(qif.count), 8);
      chk("ovf_flag9", int'(qif.overflow), 1);
      for (int k = 1; k <= 8; k++) begin
         chk($sformatf("ovf_drain%0d", k), dout(), k);
         step(1'b0, 0, 1'b1);
      end
      chk("ovf_empty", int'(qif.rready), 0);
      chk("ovf_sticky", int'(qif.overflow), 1);

      // Reset mid-operation with a push pending: everything clears without a clock edge.
      step(1'b1, 11, 1'b0);
      step(1'b1, 12, 1'b0);
      qif.wr_en   = 1'b1;
      qif.wr_data = 11'd13;
      #2 rst = 1'b0;
      #1;
      chk("arst_rready", int'(qif.rready), 0);
      chk("arst_out", dout(), 0);
      chk("arst_count", int'(qif.count), 0);
      chk("arst_full", int'(qif.full), 0);
      chk("arst_overflow", int'(qif.overflow), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      mq.delete();
      movf = 1'b0;
      qif.wr_en = 1'b0;
      chk("post_rst_rready", int'(qif.rready), 0);
      chk("post_rst_out", dout(), 0);
      step(1'b1, 77, 1'b0);
      chk("first_push_out", dout(), 77);
      chk("first_push_count", int'(qif.count), 1);

      // Full with simultaneous push and pop: 100 is accepted and drains last.
      do_reset();
      for (int v = 1; v <= 8; v++) step(1'b1, v, 1'b0);
      step(1'b1, 100, 1'b1);
      chk("fullpp_count", int'(qif.count), 8);
      chk("fullpp_full", int'(qif.full), 1);
      chk("fullpp_overflow", int'(qif.overflow), 0);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("fullpp_drain%0d", k), dout(), (k < 7) ? k + 2 : 100);
         step(1'b0, 0, 1'b1);
      end
      chk("fullpp_empty", int'(qif.count), 0);

      // Clamp boundary values.
`ifdef SOURCE_QUEUE_CLAMP_EN
      e1 = 999;
      e2 = -999;
`else
      e1 = 1023;
      e2 = -1024;
`endif
      do_reset();
      step(1'b1, 1023, 1'b0);
      step(1'b1, -1024, 1'b0);
      chk("clamp_hi", dout(), e1);
      step(1'b0, 0, 1'b1);
      chk("clamp_lo", dout(), e2);
      step(1'b0, 0, 1'b1);

      // Randomized traffic with phases biased toward filling, draining and balanced flow.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         case ((i / 200) % 3)
            0:       begin pw = 85; pr = 30; end
            1:       begin pw = 30; pr = 85; end
            default: begin pw = 60; pr = 60; end
         endcase
         r = 11'($urandom_range(0, 2047));
         if ($urandom_range(0, 9) == 0) r = ($urandom_range(0, 1) == 0) ? 11'h3FF : 11'h400;
         step($urandom_range(0, 99) < pw, int'($signed(r)), $urandom_range(0, 99) < pr);
         check_model("rand");
         if ($urandom_range(0, 999) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
